// File: rtl/vote_session_ctrl.sv
// Session controller for a 4-voter ballot path: grants one vote per cycle, closes on
// all-voted or timeout, then presents majority/tie. Optional abort input under VOTE_ABORT_EN.
module vote_session_ctrl #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 16,
    parameter int TW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef VOTE_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    input  logic [3:0] vote_req,
    input  logic [3:0] vote_val,
    output logic [3:0] vote_ack,
    output logic       busy,
    output logic [2:0] votes_cast,
    output logic       result_valid,
    output logic       result,
    output logic       tie,
    output logic       timed_out,
    input  logic       result_ack
);

    if (N_VOTERS != 4) begin : g_bad_voters
        $error("vote_session_ctrl supports exactly 4 voters");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255 || TIMEOUT > (1 << TW)) begin : g_bad_timeout
        $error("vote_session_ctrl TIMEOUT out of range");
    end

    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [3:0]    voted_reg;
    logic [3:0]    ballots_reg;
    logic [2:0]    votes_cast_reg;
    logic [TW-1:0] timer_reg;
    logic          result_reg;
    logic          tie_reg;
    logic          timed_out_reg;

    logic [3:0]    eligible;
    logic [3:0]    grant;
    logic [3:0]    collect_ack;
    logic          all_voted;
    logic          timer_last;
    logic          abort_hit;
    logic [2:0]    yes_cnt;
    logic [2:0]    no_cnt;

    // Lowest-index eligible voter wins: isolate the lowest set bit.
    assign eligible    = vote_req & ~voted_reg;
    assign grant       = eligible & (~eligible + 4'd1);
    assign collect_ack = (state_reg == S_COLLECT) ? grant : 4'd0;
    assign all_voted   = &(voted_reg | collect_ack);
    assign timer_last  = (timer_reg == LAST_TICK);

`ifdef VOTE_ABORT_EN
    assign abort_hit = abort && (state_reg == S_COLLECT || state_reg == S_EVAL);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        yes_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            yes_cnt = yes_cnt + {2'b00, ballots_reg[i]};
        end
    end
    assign no_cnt = votes_cast_reg - yes_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_COLLECT;
            end
            S_COLLECT: begin
                busy = 1'b1;
                // A final vote landing on the timeout edge still counts as all-voted.
                if (all_voted || timer_last) state_next = S_EVAL;
            end
            S_EVAL: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort_hit) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted_reg      <= 4'd0;
            ballots_reg    <= 4'd0;
            votes_cast_reg <= 3'd0;
            timer_reg      <= '0;
            result_reg     <= 1'b0;
            tie_reg        <= 1'b0;
            timed_out_reg  <= 1'b0;
        end else if (abort_hit) begin
            votes_cast_reg <= 3'd0;
            result_reg     <= 1'b0;
            tie_reg        <= 1'b0;
            timed_out_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        voted_reg      <= 4'd0;
                        ballots_reg    <= 4'd0;
                        votes_cast_reg <= 3'd0;
                        timer_reg      <= '0;
                        timed_out_reg  <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    voted_reg   <= voted_reg | collect_ack;
                    ballots_reg <= ballots_reg | (collect_ack & vote_val);
                    if (|collect_ack) votes_cast_reg <= votes_cast_reg + 3'd1;
                    timer_reg <= timer_reg + 1'b1;
                    if (timer_last && !all_voted) timed_out_reg <= 1'b1;
                end
                S_EVAL: begin
                    result_reg <= (yes_cnt > no_cnt);
                    tie_reg    <= (yes_cnt == no_cnt) && (votes_cast_reg != 3'd0);
                end
                default: ;
            endcase
        end
    end

    assign vote_ack   = collect_ack;
    assign votes_cast = votes_cast_reg;
    assign result     = result_reg;
    assign tie        = tie_reg;
    assign timed_out  = timed_out_reg;

endmodule
